pe_psum_arbiter: RTL

//  Clocked round-robin arbiter sharing one NoC packetizer port among NUM_PE processing elements.

---
 rtl/pe_psum_arbiter_pkg.sv | 50 +++++
 rtl/pe_psum_arbiter_if.sv | 35 +++
 rtl/pe_psum_arbiter_rr_arbiter.sv | 29 ++
 rtl/pe_psum_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/pe_psum_arbiter_pkg.sv
// Package pe_noc_pkg: NoC packet field layout, routing header type and the
// packet assembly helper shared by the PE arbiter and the NoC router.
package pe_noc_pkg;

   localparam int NOC_ADDR_W = 4;
   localparam int NOC_HOP_W  = 2;
   localparam int NOC_DATA_W = 40;
   localparam int NOC_PKT_W  = 1 + 2*NOC_ADDR_W + 2 + 2*NOC_HOP_W + NOC_DATA_W;

   localparam int TYPE_BIT   = NOC_PKT_W - 1;
   localparam int SRC_MSB    = TYPE_BIT - 1;
   localparam int SRC_LSB    = SRC_MSB - NOC_ADDR_W + 1;
   localparam int DEST_MSB   = SRC_LSB - 1;
   localparam int DEST_LSB   = DEST_MSB - NOC_ADDR_W + 1;
   localparam int X_DIR_BIT  = DEST_LSB - 1;
   localparam int Y_DIR_BIT  = X_DIR_BIT - 1;
   localparam int X_HOP_MSB  = Y_DIR_BIT - 1;
   localparam int X_HOP_LSB  = X_HOP_MSB - NOC_HOP_W + 1;
   localparam int Y_HOP_MSB  = X_HOP_LSB - 1;
   localparam int Y_HOP_LSB  = Y_HOP_MSB - NOC_HOP_W + 1;

   typedef struct packed {
      logic [NOC_ADDR_W-1:0] dest;
      logic                  x_dir;
      logic                  y_dir;
      logic [NOC_HOP_W-1:0]  x_hop;
      logic [NOC_HOP_W-1:0]  y_hop;
   } noc_hdr_t;

   // Place each field at its fixed bit position; payload fills everything below the header.
   function automatic logic [NOC_PKT_W-1:0] pack_pkt(
      input logic                  pkt_type,
      input logic [NOC_ADDR_W-1:0] src,
      input noc_hdr_t              hdr,
      input logic [NOC_DATA_W-1:0] data
   );
      logic [NOC_PKT_W-1:0] p;
      p                     = '0;
      p[TYPE_BIT]           = pkt_type;
      p[SRC_MSB:SRC_LSB]    = src;
      p[DEST_MSB:DEST_LSB]  = hdr.dest;
      p[X_DIR_BIT]          = hdr.x_dir;
      p[Y_DIR_BIT]          = hdr.y_dir;
      p[X_HOP_MSB:X_HOP_LSB] = hdr.x_hop;
      p[Y_HOP_MSB:Y_HOP_LSB] = hdr.y_hop;
      p[Y_HOP_LSB-1:0]      = data;
      return p;
   endfunction

endpackage

// File: rtl/pe_psum_arbiter_if.sv
// PE-side request bus plus router-side output bus of the psum arbiter.
// The slave modport is the arbiter's view, master is the surrounding system.
interface pe_psum_arbiter_if #(
   parameter int NUM_PE = 4,
   parameter int ADDR_W = 4,
   parameter int HOP_W  = 2,
   parameter int DATA_W = 40
);
   localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int PKT_W = 1 + 2*ADDR_W + 2 + 2*HOP_W + DATA_W;

   logic [NUM_PE-1:0]        req_valid;
   logic [NUM_PE-1:0]        req_ready;
   logic [NUM_PE*ADDR_W-1:0] req_dest;
   logic [NUM_PE-1:0]        req_xdir;
   logic [NUM_PE-1:0]        req_ydir;
   logic [NUM_PE*HOP_W-1:0]  req_xhop;
   logic [NUM_PE*HOP_W-1:0]  req_yhop;
   logic [NUM_PE*DATA_W-1:0] req_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [PKT_W-1:0]         out_packet;
   logic [IDX_W-1:0]         out_src_idx;

   modport slave (
      input  req_valid, req_dest, req_xdir, req_ydir, req_xhop, req_yhop, req_data, out_ready,
      output req_ready, out_valid, out_packet, out_src_idx
   );

   modport master (
      output req_valid, req_dest, req_xdir, req_ydir, req_xhop, req_yhop, req_data, out_ready,
      input  req_ready, out_valid, out_packet, out_src_idx
   );

endinterface

// File: rtl/pe_psum_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. The requester right after
// ptr has highest priority, searching upward and wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   int   idx;
   logic found;

   // Walk ptr+1, ptr+2, ... and grant the first active requester found.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_psum_arbiter.sv
// pe_psum_arbiter: round-robin share of one NoC packetizer port among NUM_PE
// processing elements, with a single registered packet output.
// Optional feature macro: PE_ARB_STATS_EN adds per-PE saturating accept counters.
// Field widths are shared with pe_noc_pkg; ADDR_W/HOP_W/DATA_W must match it.
module pe_psum_arbiter
   import pe_noc_pkg::*;
#(
   parameter int NUM_PE   = 4,
   parameter int ADDR_W   = NOC_ADDR_W,
   parameter int HOP_W    = NOC_HOP_W,
   parameter int DATA_W   = NOC_DATA_W,
   parameter int SRC_BASE = 0,
   parameter bit PKT_TYPE = 1'b0,
   localparam int IDX_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   pe_psum_arbiter_if.slave  bus
`ifdef PE_ARB_STATS_EN
   ,
   input  logic              stat_clr,
   input  logic [IDX_W-1:0]  stat_sel,
   output logic [15:0]       stat_cnt
`endif
);

   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  gnt_idx;
   logic [NUM_PE-1:0] gnt;
   logic              can_accept;
   logic              accept;
   noc_hdr_t          hdr;
   logic [ADDR_W-1:0] src;
   logic [DATA_W-1:0] data;

   rr_arbiter #(.N(NUM_PE)) u_rr (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt)
   );

   // A new packet may enter when the output slot is empty or draining this cycle;
   // while reset is held no PE is told it was accepted.
   assign can_accept    = ~bus.out_valid | bus.out_ready;
   assign bus.req_ready = gnt & {NUM_PE{can_accept & rst_n}};
   assign accept        = |bus.req_ready;

   // Encode the one-hot grant and gather the winning PE's fields.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (gnt[i]) gnt_idx = IDX_W'(i);
      end
      hdr.dest  = bus.req_dest[gnt_idx*ADDR_W +: ADDR_W];
      hdr.x_dir = bus.req_xdir[gnt_idx];
      hdr.y_dir = bus.req_ydir[gnt_idx];
      hdr.x_hop = bus.req_xhop[gnt_idx*HOP_W +: HOP_W];
      hdr.y_hop = bus.req_yhop[gnt_idx*HOP_W +: HOP_W];
      data      = bus.req_data[gnt_idx*DATA_W +: DATA_W];
      src       = ADDR_W'(SRC_BASE + int'(gnt_idx));
   end

   // Output register: load on accept (replacing a packet draining in the same
   // cycle), clear valid on a plain drain, otherwise hold everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid   <= 1'b0;
         bus.out_packet  <= '0;
         bus.out_src_idx <= '0;
         ptr             <= IDX_W'(NUM_PE - 1);
      end else if (accept) begin
         bus.out_valid   <= 1'b1;
         bus.out_packet  <= pack_pkt(PKT_TYPE, src, hdr, data);
         bus.out_src_idx <= gnt_idx;
         ptr             <= gnt_idx;
      end else if (bus.out_ready) begin
         bus.out_valid   <= 1'b0;
      end
   end

`ifdef PE_ARB_STATS_EN
   logic [15:0] cnt [NUM_PE];

   // Per-PE accept counters: clear wins over increment, increments saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PE; i++) cnt[i] <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < NUM_PE; i++) cnt[i] <= '0;
      end else if (accept && cnt[gnt_idx] != 16'hFFFF) begin
         cnt[gnt_idx] <= cnt[gnt_idx] + 16'd1;
      end
   end

   assign stat_cnt = cnt[stat_sel];
`endif

endmodule
